// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control FSM / mult-div units and the
// multiply/divide sequencer. The sequencer takes the slave view; whoever
// drives requests and unit flags (control FSM, units, or a bench) takes
// the master view.
interface muldiv_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             req;
    logic             op;
    logic             mult_fim;
    logic             div_fim;
    logic             DividedByZero;
    logic             mult_start;
    logic             div_start;
    logic             HISelector;
    logic             LOSelector;
    logic             RegHIWrite;
    logic             RegLOWrite;
    logic             busy;
    logic             done;
    logic             exc_div0;
    logic             exc_timeout;
    logic [CNT_W-1:0] last_cycles;

    modport master (
        output req, op, mult_fim, div_fim, DividedByZero,
        input  mult_start, div_start, HISelector, LOSelector,
               RegHIWrite, RegLOWrite, busy, done, exc_div0,
               exc_timeout, last_cycles
    );

    modport slave (
        input  req, op, mult_fim, div_fim, DividedByZero,
        output mult_start, div_start, HISelector, LOSelector,
               RegHIWrite, RegLOWrite, busy, done, exc_div0,
               exc_timeout, last_cycles
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer for the multicycle MIPS datapath.
// Takes a one-cycle request from the main control FSM, pulses the start of
// the selected unit, waits for its completion flag (or divide-by-zero, or a
// bounded timeout), then writes HI/LO and reports the outcome. All outputs
// are Moore-decoded from registered state so no input reaches an output.
module muldiv_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_EXC_DZ = 3'd5,
        ST_EXC_TO = 3'd6
    } state_t;

    // cnt holds (WAIT cycles seen - 1) during WAIT, so the last allowed
    // WAIT cycle is the one where cnt equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           next_state_s;
    logic             op_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] last_cycles_r;

    logic             sel_fim_s;
    logic             dz_hit_s;
    logic             to_hit_s;

    // Only the selected unit's flag counts; the other unit's flag is ignored.
    assign sel_fim_s = op_q_r ? bus.div_fim : bus.mult_fim;
    assign dz_hit_s  = op_q_r & bus.DividedByZero;
    assign to_hit_s  = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; WAIT exits in priority div0 > completion > timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (dz_hit_s) begin
                    next_state_s = ST_EXC_DZ;
                end else if (sel_fim_s) begin
                    next_state_s = ST_WRITE;
                end else if (to_hit_s) begin
                    next_state_s = ST_EXC_TO;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WRITE:  next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            ST_EXC_DZ: next_state_s = ST_IDLE;
            ST_EXC_TO: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Op latch, WAIT counter and last-operation cycle count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q_r        <= 1'b0;
            cnt_r         <= CNT_ZERO;
            last_cycles_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        op_q_r <= bus.op;
                    end
                end
                ST_START: begin
                    cnt_r <= CNT_ZERO;
                end
                ST_WAIT: begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (next_state_s != ST_WAIT) begin
                        last_cycles_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        bus.mult_start  = 1'b0;
        bus.div_start   = 1'b0;
        bus.RegHIWrite  = 1'b0;
        bus.RegLOWrite  = 1'b0;
        bus.done        = 1'b0;
        bus.exc_div0    = 1'b0;
        bus.exc_timeout = 1'b0;
        bus.busy        = (state_r != ST_IDLE);
        bus.HISelector  = op_q_r;
        bus.LOSelector  = op_q_r;
        bus.last_cycles = last_cycles_r;
        case (state_r)
            ST_START: begin
                bus.mult_start = ~op_q_r;
                bus.div_start  = op_q_r;
            end
            ST_WRITE: begin
                bus.RegHIWrite = 1'b1;
                bus.RegLOWrite = 1'b1;
            end
            ST_DONE:   bus.done        = 1'b1;
            ST_EXC_DZ: bus.exc_div0    = 1'b1;
            ST_EXC_TO: bus.exc_timeout = 1'b1;
            default:   bus.busy        = (state_r != ST_IDLE);
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: operations are described at transaction level
// (op, WAIT cycle of completion, WAIT cycle of divide-by-zero); the model
// derives the outcome and the per-cycle output timeline from the timing
// rules, and one compare process checks every cycle against it.
module tb_muldiv_sequencer;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    muldiv_sequencer_if #(.CNT_W(CNT_W)) bus ();

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic             mult_start;
        logic             div_start;
        logic             hisel;
        logic             losel;
        logic             hiw;
        logic             low;
        logic             busy;
        logic             done;
        logic             exc_div0;
        logic             exc_to;
        logic [CNT_W-1:0] last;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_cyc = -1;
    int dz_cyc = -1;
    int to_cyc = -1;
    int start_cnt = 0;
    int write_cnt = 0;

    // model state carried between operations
    logic             m_opq = 1'b0;
    logic [CNT_W-1:0] m_last = '0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t o;
        o = {bus.mult_start, bus.div_start, bus.HISelector, bus.LOSelector,
             bus.RegHIWrite, bus.RegLOWrite, bus.busy, bus.done, bus.exc_div0,
             bus.exc_timeout, bus.last_cycles};
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t e;
        e = '0;
        e.hisel = m_opq;
        e.losel = m_opq;
        e.last  = m_last;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Per-cycle compare against the model timeline, plus event bookkeeping.
    always @(negedge clock) begin
        obs_t act;
        obs_t e;
        act = sample();
        if (act.done)     done_cyc = cyc;
        if (act.exc_div0) dz_cyc = cyc;
        if (act.exc_to)   to_cyc = cyc;
        start_cnt = start_cnt + int'(act.mult_start) + int'(act.div_start);
        write_cnt = write_cnt + int'(act.hiw);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act === e) passes++;
            else $display("FAIL cycle_%0d outputs: got %h expected %h", cyc, act, e);
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic drive(input logic r, input logic o, input logic mf,
                         input logic df, input logic dz, input obs_t e);
        @(posedge clock);
        #1;
        bus.req = r;
        bus.op = o;
        bus.mult_fim = mf;
        bus.div_fim = df;
        bus.DividedByZero = dz;
        exp_q.push_back(e);
    endtask

    task automatic clear_events();
        done_cyc = -1;
        dz_cyc = -1;
        to_cyc = -1;
        start_cnt = 0;
        write_cnt = 0;
    endtask

    // One operation: fim_k / dz_k are the WAIT cycles (1-based) where the
    // selected unit's flag / DividedByZero are raised; out-of-window = never.
    task automatic run_op(input logic o, input int fim_k, input int dz_k,
                          input bit noise, input int gap, output int req_cyc);
        int k;
        int outcome;   // 1 write, 2 div0, 3 timeout
        int ncyc;
        obs_t e;
        logic r, opin, sf, mf, df, dz, quiet;
        k = 0;
        outcome = 0;
        req_cyc = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (outcome == 0) begin
                if (o && dz_k == i) begin k = i; outcome = 2; end
                else if (fim_k == i) begin k = i; outcome = 1; end
                else if (i == TIMEOUT) begin k = i; outcome = 3; end
            end
        end
        ncyc = (outcome == 1) ? k + 4 : k + 3;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                e = idle_exp();
            end else begin
                e = '0;
                e.busy  = 1'b1;
                e.hisel = o;
                e.losel = o;
                e.last  = (c >= k + 2) ? CNT_W'(k) : m_last;
                if (c == 1) begin
                    e.mult_start = ~o;
                    e.div_start  = o;
                end
                if (c == k + 2) begin
                    if (outcome == 1) begin e.hiw = 1'b1; e.low = 1'b1; end
                    if (outcome == 2) e.exc_div0 = 1'b1;
                    if (outcome == 3) e.exc_to = 1'b1;
                end
                if (c == k + 3) e.done = 1'b1;
            end
            // flags may be noisy only where they cannot be sampled
            quiet = (c >= 2 && c <= k + 1);
            r    = (c == 0) ? 1'b1 : (noise ? rb() : 1'b0);
            opin = (c == 0) ? o : rb();
            sf   = (c == fim_k + 1) || (!quiet && noise && rb());
            if (o) dz = (c == dz_k + 1) || (!quiet && noise && rb());
            else   dz = noise && rb();
            mf = o ? (noise && rb()) : sf;
            df = o ? sf : (noise && rb());
            drive(r, opin, mf, df, dz, e);
            if (c == 0) req_cyc = cyc;
        end
        m_opq  = o;
        m_last = CNT_W'(k);
        for (int g = 0; g < gap; g++) begin
            drive(1'b0, rb(), rb(), rb(), rb(), idle_exp());
        end
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc;
        obs_t e;
        bus.req = 1'b0;
        bus.op = 1'b0;
        bus.mult_fim = 1'b0;
        bus.div_fim = 1'b0;
        bus.DividedByZero = 1'b0;

        #2;
        check("reset_state", int'(sample()), 0);
        #10 reset = 1'b1;

        // Mult, fim in WAIT cycle 3
        clear_events();
        run_op(1'b0, 3, 0, 1'b0, 1, rc);
        settle();
        check("mult_done_after_req", done_cyc - rc, 6);
        check("mult_last_cycles", int'(bus.last_cycles), 3);
        check("mult_start_pulses", start_cnt, 1);
        check("mult_write_cycles", write_cnt, 1);

        // Div, fim in WAIT cycle 1
        clear_events();
        run_op(1'b1, 1, 0, 1'b0, 1, rc);
        settle();
        check("div_done_after_req", done_cyc - rc, 4);
        check("div_selector", int'(bus.HISelector), 1);
        check("div_write_cycles", write_cnt, 1);

        // Divide by zero together with fim in WAIT cycle 2
        clear_events();
        run_op(1'b1, 2, 2, 1'b0, 1, rc);
        settle();
        check("dz_pulse_after_req", dz_cyc - rc, 4);
        check("dz_no_write", write_cnt, 0);
        check("dz_no_done", done_cyc, -1);

        // Timeout, then a fresh request
        clear_events();
        run_op(1'b0, TIMEOUT + 2, 0, 1'b0, 1, rc);
        settle();
        check("to_pulse_after_req", to_cyc - rc, TIMEOUT + 2);
        check("to_last_cycles", int'(bus.last_cycles), TIMEOUT);
        check("to_no_write", write_cnt, 0);
        clear_events();
        run_op(1'b0, 1, 0, 1'b0, 1, rc);
        settle();
        check("after_to_done", done_cyc - rc, 4);

        // Spurious req / mult_fim / DividedByZero during a div
        clear_events();
        run_op(1'b1, 3, 0, 1'b1, 1, rc);
        settle();
        check("spur_start_pulses", start_cnt, 1);
        check("spur_done_after_req", done_cyc - rc, 6);

        // Asynchronous reset during WAIT cycle 2
        e = idle_exp();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e);
        e = '0; e.busy = 1'b1; e.hisel = 1'b1; e.losel = 1'b1; e.div_start = 1'b1; e.last = m_last;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
        e.div_start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("reset_mid_wait_outputs", int'(sample()), 0);
        @(posedge clock);
        #2 reset = 1'b1;
        m_opq = 1'b0;
        m_last = '0;
        clear_events();
        run_op(1'b0, 2, 0, 1'b0, 1, rc);
        settle();
        check("after_reset_done", done_cyc - rc, 5);

        // Randomized operations with noise and back-to-back requests
        for (int n = 0; n < 150; n++) begin
            run_op(rb(), int'($urandom_range(1, TIMEOUT + 1)),
                   int'($urandom_range(0, TIMEOUT + 1)), 1'b1,
                   int'($urandom_range(0, 2)), rc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle_exp());
        settle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
